// File: rtl/rv32i_encoder_if.sv
// Operation stream in, instruction-word stream out, both valid/ready.
// The encoder sits on the slave side; the producer/consumer sits on the master side.
interface rv32i_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [2:0]        in_funct3;
    logic              in_alt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_op, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_op, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/rv32i_encoder.sv
// RV32I encoder: abstract ops in, addressed instruction words out; LI expansion when RV32I_ENC_LI_EN is defined.
// Latency: op accepted in cycle N is on out_* in cycle N+1; one word per cycle (LI above 12 bits takes two).
// Backpressure: one output register; in_ready when empty or draining, never while an LI's LUI is held.
module rv32i_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    rv32i_encoder_if.slave bus,
    input  logic           addr_load,
    output logic           err,
    input  logic           err_clr
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [3:0] OP_LUI    = 4'd0;
    localparam logic [3:0] OP_AUIPC  = 4'd1;
    localparam logic [3:0] OP_JAL    = 4'd2;
    localparam logic [3:0] OP_JALR   = 4'd3;
    localparam logic [3:0] OP_BRANCH = 4'd4;
    localparam logic [3:0] OP_LOAD   = 4'd5;
    localparam logic [3:0] OP_STORE  = 4'd6;
    localparam logic [3:0] OP_OPIMM  = 4'd7;
    localparam logic [3:0] OP_OP     = 4'd8;
    localparam logic [3:0] OP_FENCE  = 4'd9;
    localparam logic [3:0] OP_ECALL  = 4'd10;
    localparam logic [3:0] OP_EBREAK = 4'd11;

`ifdef RV32I_ENC_LI_EN
    localparam logic [3:0] OP_LI     = 4'd12;
    typedef enum logic [1:0] {EMPTY, FULL, LI_HI, LI_LO} state_t;
`else
    typedef enum logic [0:0] {EMPTY, FULL} state_t;
`endif

    state_t            state;
    logic              valid_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic              in_ready;
    logic              accept;
    logic              fire_out;

    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic        fits_i, fits_b, fits_j, fits_sh, lo_zero;
    logic [31:0] enc_word;
    logic        enc_err;

    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;
    assign f3  = bus.in_funct3;
    assign imm = bus.in_imm;

    // Signed range checks: every bit above the field's sign bit must equal it.
    assign fits_i  = (imm[31:11] == {21{imm[11]}});
    assign fits_b  = (imm[31:12] == {20{imm[12]}}) && !imm[0];
    assign fits_j  = (imm[31:20] == {12{imm[20]}}) && !imm[0];
    assign fits_sh = (imm[31:5] == '0);
    assign lo_zero = (imm[11:0] == '0);

`ifdef RV32I_ENC_LI_EN
    logic [19:0] li_hi;
    logic [31:0] enc_lo_word;
    logic        enc_two;
    logic [31:0] pend_q;
    // ADDI sign-extends its 12 bits, so the upper part is rounded up when bit 11 is set.
    assign li_hi = imm[31:12] + {19'd0, imm[11]};
`endif

    always_comb begin
        enc_word = NOP;
        enc_err  = 1'b0;
`ifdef RV32I_ENC_LI_EN
        enc_lo_word = NOP;
        enc_two     = 1'b0;
`endif
        case (bus.in_op)
            OP_LUI: begin
                enc_word = {imm[31:12], rd, 7'b0110111};
                enc_err  = !lo_zero;
            end
            OP_AUIPC: begin
                enc_word = {imm[31:12], rd, 7'b0010111};
                enc_err  = !lo_zero;
            end
            OP_JAL: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                enc_err  = !fits_j;
            end
            OP_JALR: begin
                enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
                enc_err  = !fits_i;
            end
            OP_BRANCH: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
                enc_err  = !fits_b || (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LOAD: begin
                enc_word = {imm[11:0], rs1, f3, rd, 7'b0000011};
                enc_err  = !fits_i || (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OP_STORE: begin
                enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
                enc_err  = !fits_i || (f3 > 3'b010);
            end
            OP_OPIMM: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    enc_word = {1'b0, bus.in_alt, 5'b0, imm[4:0], rs1, f3, rd, 7'b0010011};
                    enc_err  = !fits_sh;
                end else begin
                    enc_word = {imm[11:0], rs1, f3, rd, 7'b0010011};
                    enc_err  = !fits_i;
                end
            end
            OP_OP:     enc_word = {1'b0, bus.in_alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
            OP_FENCE:  enc_word = 32'h0FF0_000F;
            OP_ECALL:  enc_word = 32'h0000_0073;
            OP_EBREAK: enc_word = 32'h0010_0073;
`ifdef RV32I_ENC_LI_EN
            OP_LI: begin
                if (fits_i) begin
                    enc_word = {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011};
                end else if (lo_zero) begin
                    enc_word = {imm[31:12], rd, 7'b0110111};
                end else begin
                    enc_word    = {li_hi, rd, 7'b0110111};
                    enc_lo_word = {imm[11:0], rd, 3'b000, rd, 7'b0010011};
                    enc_two     = 1'b1;
                end
            end
`endif
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_word = NOP;
`ifdef RV32I_ENC_LI_EN
            enc_two  = 1'b0;
`endif
        end
    end

`ifdef RV32I_ENC_LI_EN
    assign in_ready = (state == EMPTY) || (((state == FULL) || (state == LI_LO)) && bus.out_ready);
`else
    assign in_ready = (state == EMPTY) || ((state == FULL) && bus.out_ready);
`endif
    assign accept   = bus.in_valid && in_ready;
    assign fire_out = valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_addr  = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            instr_q <= '0;
            addr_q  <= BASE_ADDR;
            err     <= 1'b0;
`ifdef RV32I_ENC_LI_EN
            pend_q  <= '0;
`endif
        end else begin
            // The address register always names the word on (or next onto) the output.
            if (addr_load) begin
                addr_q <= BASE_ADDR;
            end else if (fire_out) begin
                addr_q <= addr_q + ADDR_W'(4);
            end

            if (accept && enc_err) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
`ifdef RV32I_ENC_LI_EN
                LI_HI: begin
                    if (bus.out_ready) begin
                        instr_q <= pend_q;
                        state   <= LI_LO;
                    end
                end
`endif
                default: begin
                    if (accept) begin
                        instr_q <= enc_word;
                        valid_q <= 1'b1;
`ifdef RV32I_ENC_LI_EN
                        pend_q  <= enc_lo_word;
                        state   <= enc_two ? LI_HI : FULL;
`else
                        state   <= FULL;
`endif
                    end else if (fire_out) begin
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_encoder.sv
// Randomized bench for rv32i_encoder against a queue-based reference model of the encoder.
module tb_rv32i_encoder;
    localparam int               ADDR_W = 16;
    localparam logic [15:0]      BASE   = 16'hFFF0;
    localparam logic [31:0]      NOP    = 32'h0000_0013;

    logic clk;
    logic rst_n;
    logic addr_load;
    logic err;
    logic err_clr;

    rv32i_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    rv32i_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .addr_load (addr_load),
        .err       (err),
        .err_clr   (err_clr)
    );

    int tot = 0;
    int bad = 0;
    bit rand_mode = 0;

    logic [31:0]       q[$];
    logic [ADDR_W-1:0] m_addr;
    bit                m_err;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input int top7, input int f20, input int f15,
                                         input int f12, input int f7, input int opc);
        return 32'((top7 << 25) | (f20 << 20) | (f15 << 15) | (f12 << 12) | (f7 << 7) | opc);
    endfunction

    // Reference encoder built from the instruction formats with integer arithmetic.
    function automatic void model_encode(input int op, input int f3, input int alt, input int rd,
                                         input int rs1, input int rs2, input logic [31:0] imm,
                                         output logic [31:0] w0, output logic [31:0] w1,
                                         output int n, output bit e);
        int s, im12, top, lo5, jf, hi;
        logic [31:0] u;
        bit in_i;
        u    = imm;
        s    = int'($signed(imm));
        im12 = int'(u & 32'hFFF);
        in_i = (s >= -2048) && (s <= 2047);
        w0 = NOP; w1 = NOP; n = 1; e = 0;
        case (op)
            0, 1: begin
                e  = (u & 32'hFFF) != 0;
                w0 = (u & 32'hFFFF_F000) | 32'(rd << 7) | ((op == 0) ? 32'h37 : 32'h17);
            end
            2: begin
                e  = (s < -(1 << 20)) || (s > (1 << 20) - 2) || (u[0] == 1'b1);
                jf = int'((((u >> 20) & 1) << 19) | (((u >> 1) & 1023) << 9) |
                          (((u >> 11) & 1) << 8) | ((u >> 12) & 255));
                w0 = (32'(jf) << 12) | 32'(rd << 7) | 32'h6F;
            end
            3: begin
                e  = !in_i;
                w0 = pack(im12 >> 5, im12 & 31, rs1, 0, rd, 'h67);
            end
            4: begin
                e   = (s < -4096) || (s > 4094) || (u[0] == 1'b1) || (f3 == 2) || (f3 == 3);
                top = int'((((u >> 12) & 1) << 6) | ((u >> 5) & 63));
                lo5 = int'((((u >> 1) & 15) << 1) | ((u >> 11) & 1));
                w0  = pack(top, rs2, rs1, f3, lo5, 'h63);
            end
            5: begin
                e  = !in_i || (f3 == 3) || (f3 == 6) || (f3 == 7);
                w0 = pack(im12 >> 5, im12 & 31, rs1, f3, rd, 'h03);
            end
            6: begin
                e  = !in_i || (f3 > 2);
                w0 = pack(im12 >> 5, rs2, rs1, f3, im12 & 31, 'h23);
            end
            7: begin
                if (f3 == 1 || f3 == 5) begin
                    e  = (s < 0) || (s > 31);
                    w0 = pack(alt * 32, s & 31, rs1, f3, rd, 'h13);
                end else begin
                    e  = !in_i;
                    w0 = pack(im12 >> 5, im12 & 31, rs1, f3, rd, 'h13);
                end
            end
            8:  w0 = pack(alt * 32, rs2, rs1, f3, rd, 'h33);
            9:  w0 = 32'h0FF0_000F;
            10: w0 = 32'h0000_0073;
            11: w0 = 32'h0010_0073;
`ifdef RV32I_ENC_LI_EN
            12: begin
                if (in_i) begin
                    w0 = pack(im12 >> 5, im12 & 31, 0, 0, rd, 'h13);
                end else begin
                    hi = int'(((u >> 12) + ((u >> 11) & 1)) & 32'hFFFFF);
                    w0 = (32'(hi) << 12) | 32'(rd << 7) | 32'h37;
                    if (im12 != 0) begin
                        w1 = pack(im12 >> 5, im12 & 31, rd, 0, rd, 'h13);
                        n  = 2;
                    end
                end
            end
`endif
            default: e = 1;
        endcase
        if (e) begin
            w0 = NOP;
            n  = 1;
        end
    endfunction

    // One compare process: outputs checked against the model every cycle, model advanced per handshake.
    always @(negedge clk) begin
        logic [31:0] w0, w1;
        int n;
        bit e, exp_rdy, fire, acc;
        if (!rst_n) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_addr", bus.out_addr, BASE);
            chk("rst_out_instr", bus.out_instr, 0);
            chk("rst_err", err, 0);
            chk("rst_in_ready", bus.in_ready, 1);
            q.delete();
            m_addr = BASE;
            m_err  = 0;
        end else begin
            exp_rdy = (q.size() == 0) || ((q.size() == 1) && bus.out_ready);
            chk("out_valid", bus.out_valid, (q.size() != 0));
            if (q.size() != 0) chk("out_instr", bus.out_instr, q[0]);
            chk("out_addr", bus.out_addr, m_addr);
            chk("in_ready", bus.in_ready, exp_rdy);
            chk("err", err, m_err);
            fire = (q.size() != 0) && bus.out_ready;
            acc  = bus.in_valid && exp_rdy;
            if (fire) void'(q.pop_front());
            if (addr_load) m_addr = BASE;
            else if (fire) m_addr = m_addr + 4;
            e = 0;
            if (acc) begin
                model_encode(int'(bus.in_op), int'(bus.in_funct3), int'(bus.in_alt), int'(bus.in_rd),
                             int'(bus.in_rs1), int'(bus.in_rs2), bus.in_imm, w0, w1, n, e);
                q.push_back(w0);
                if (n == 2) q.push_back(w1);
            end
            if (e) m_err = 1;
            else if (err_clr) m_err = 0;
        end
    end

    // Random output backpressure, address reloads and error clears.
    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            addr_load     = ($urandom_range(0, 40) == 0);
            err_clr       = ($urandom_range(0, 10) == 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called and returns at posedge+1; returns right after the accepting edge.
    task automatic send(input int op, input int f3, input int alt, input int rd,
                        input int rs1, input int rs2, input logic [31:0] imm);
        int  waited;
        bit  done;
        waited = 0;
        done   = 0;
        bus.in_valid  = 1;
        bus.in_op     = 4'(op);
        bus.in_funct3 = 3'(f3);
        bus.in_alt    = 1'(alt);
        bus.in_rd     = 5'(rd);
        bus.in_rs1    = 5'(rs1);
        bus.in_rs2    = 5'(rs2);
        bus.in_imm    = imm;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) done = 1;
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 60) begin
                    tot++;
                    bad++;
                    $display("FAIL send_timeout op=%0d actual=not_accepted required=accepted", op);
                    done = 1;
                end
            end
        end
        bus.in_valid = 0;
    endtask

    logic [31:0] bnd [0:17] = '{32'hFFFF_F7FF, 32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800,
                                 32'hFFFF_F000, 32'hFFFF_EFFE, 32'h0000_0FFE, 32'h0000_1000,
                                 32'hFFF0_0000, 32'h000F_FFFE, 32'h0010_0000, 32'h0000_0000,
                                 32'h0000_001F, 32'h0000_0020, 32'hFFFF_FFFF, 32'h1234_5FFF,
                                 32'h1234_5000, 32'h7FFF_F800};

    initial begin
        logic [31:0] w0, w1, imm;
        int n;
        bit e;
        rst_n = 1;
        addr_load = 0;
        err_clr = 0;
        bus.in_valid = 0;
        bus.in_op = 0;
        bus.in_funct3 = 0;
        bus.in_alt = 0;
        bus.in_rd = 0;
        bus.in_rs1 = 0;
        bus.in_rs2 = 0;
        bus.in_imm = 0;
        bus.out_ready = 1;
        #1 rst_n = 0;
        idle(3);
        rst_n = 1;
        idle(1);

        // Hand-computed encodings pin the reference model.
        model_encode(7, 0, 0, 1, 0, 0, 32'd5, w0, w1, n, e);
        chk("pin_addi", w0, 32'h0050_0093);
        model_encode(4, 0, 0, 0, 1, 2, 32'd8, w0, w1, n, e);
        chk("pin_beq", w0, 32'h0020_8463);
        model_encode(4, 0, 0, 0, 1, 2, 32'd9, w0, w1, n, e);
        chk("pin_beq_odd_err", e, 1);
        model_encode(8, 5, 1, 3, 4, 5, 32'd0, w0, w1, n, e);
        chk("pin_sra", w0, 32'h4052_51B3);
        model_encode(2, 0, 0, 1, 0, 0, 32'd2048, w0, w1, n, e);
        chk("pin_jal", w0, 32'h0010_00EF);
        model_encode(6, 2, 0, 0, 2, 3, 32'hFFFF_FFFC, w0, w1, n, e);
        chk("pin_sw", w0, 32'hFE31_2E23);
        model_encode(7, 1, 0, 1, 0, 0, 32'd32, w0, w1, n, e);
        chk("pin_slli32_err", e, 1);
`ifdef RV32I_ENC_LI_EN
        model_encode(12, 0, 0, 5, 0, 0, 32'h1234_5FFF, w0, w1, n, e);
        chk("pin_li_lui", w0, 32'h1234_62B7);
        chk("pin_li_addi", w1, 32'hFFF2_8293);
`endif

        // First op after reset: word at BASE one cycle after accept.
        send(7, 0, 0, 1, 0, 0, 32'd5);
        @(negedge clk);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_instr", bus.out_instr, 32'h0050_0093);
        chk("t1_addr", bus.out_addr, BASE);
        @(posedge clk); #1;

        // Legal branch then misaligned branch; error sticky until cleared.
        send(4, 0, 0, 0, 1, 2, 32'd8);
        send(4, 0, 0, 0, 1, 2, 32'd9);
        @(negedge clk);
        chk("t2_nop", bus.out_instr, NOP);
        chk("t2_err", err, 1);
        @(posedge clk); #1;
        err_clr = 1;
        idle(1);
        err_clr = 0;
        @(negedge clk);
        chk("t2_err_clr", err, 0);
        @(posedge clk); #1;

        // LI with rounding of the upper part.
        send(12, 0, 0, 5, 0, 0, 32'h1234_5FFF);
        @(negedge clk);
`ifdef RV32I_ENC_LI_EN
        chk("t3_lui", bus.out_instr, 32'h1234_62B7);
        chk("t3_ready_low", bus.in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_addi", bus.out_instr, 32'hFFF2_8293);
`else
        chk("t3_li_illegal", bus.out_instr, NOP);
        chk("t3_li_err", err, 1);
`endif
        @(posedge clk); #1;
        idle(2);

        // Output stall: word and address hold, no new op accepted.
        bus.out_ready = 0;
        send(8, 5, 1, 3, 4, 5, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_instr", bus.out_instr, 32'h4052_51B3);
            chk("t4_hold_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1;
        send(7, 1, 0, 1, 0, 0, 32'd32);
        @(negedge clk);
        chk("t4_shamt_nop", bus.out_instr, NOP);
        chk("t4_shamt_err", err, 1);
        @(posedge clk); #1;
        idle(1);

        // Address reload while a word is held, then wrap of the address counter.
        bus.out_ready = 0;
        send(10, 0, 0, 0, 0, 0, 32'd0);
        addr_load = 1;
        idle(1);
        addr_load = 0;
        @(negedge clk);
        chk("t5_reload_addr", bus.out_addr, BASE);
        chk("t5_reload_instr", bus.out_instr, 32'h0000_0073);
        @(posedge clk); #1;
        bus.out_ready = 1;
        for (int i = 1; i <= 4; i++) send(7, 0, 0, i, 0, 0, 32'(i));
        @(negedge clk);
        chk("t5_wrap_addr", bus.out_addr, 16'h0000);
        @(posedge clk); #1;

        // A new error in the same cycle as err_clr keeps err set.
        err_clr = 1;
        send(15, 0, 0, 0, 0, 0, 32'd0);
        err_clr = 0;
        @(negedge clk);
        chk("t6_err_wins", err, 1);
        @(posedge clk); #1;
        err_clr = 1;
        idle(1);
        err_clr = 0;
        idle(1);

        // Asynchronous reset with an LI half emitted.
        bus.out_ready = 0;
        send(12, 0, 0, 7, 0, 0, 32'h1234_5FFF);
        rst_n = 0;
        #1;
        chk("t7_rst_valid", bus.out_valid, 0);
        chk("t7_rst_addr", bus.out_addr, BASE);
        @(posedge clk); #1;
        rst_n = 1;
        bus.out_ready = 1;
        idle(4);

        // Randomized traffic checked by the compare process.
        rand_mode = 1;
        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(0, 4))
                0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1:       imm = bnd[$urandom_range(0, 17)];
                2:       imm = $urandom;
                3:       imm = 32'($urandom_range(0, 40));
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
            send($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
        end
        rand_mode = 0;
        @(posedge clk); #2;
        bus.out_ready = 1;
        addr_load = 0;
        err_clr = 0;
        idle(5);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog actual=running required=finished");
        $display("test done: total=%0d bad=%0d", tot, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
